// File: rtl/frame_proto_pkg.sv
// Shared protocol constants and rx parser state encoding for the N64 TAS
// frame path (UART bytes in, controller queue writes and host requests out).
package frame_proto_pkg;

  localparam logic [7:0] CMD_FRAME_DEFAULT    = 8'h41;
  localparam logic [7:0] CMD_RESET_DEFAULT    = 8'h52;
  localparam logic [7:0] TX_REQUEST_DEFAULT   = 8'h61;
  localparam logic [7:0] TX_RESET_ACK_DEFAULT = 8'h01;

  localparam int unsigned FRAME_BYTES = 4;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_DATA  = 2'd1;
  localparam rx_state_t ST_WRITE = 2'd2;
  localparam rx_state_t ST_ACK   = 2'd3;

endpackage

// File: rtl/tx_request_arbiter.sv
// Turns console request edges and reset acknowledgements into single
// host-bound bytes, one per cycle, only while the UART transmitter is ready.
module tx_request_arbiter
  import frame_proto_pkg::*;
#(
  parameter int unsigned NUM_CONSOLES = 1,
  parameter logic [7:0]  TX_REQUEST   = TX_REQUEST_DEFAULT,
  parameter logic [7:0]  TX_RESET_ACK = TX_RESET_ACK_DEFAULT
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [NUM_CONSOLES-1:0] request_frame,
  input  logic                    ack_set,
  input  logic                    tx_ready,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid
);

  logic [NUM_CONSOLES-1:0] req_q;
  logic                    req_pending;
  logic                    ack_pending;
  logic                    rise;
  logic                    ack_grant;
  logic                    req_grant;

  assign rise      = |(request_frame & ~req_q);
  assign ack_grant = tx_ready & ack_pending;
  assign req_grant = tx_ready & ~ack_pending & req_pending;

  assign tx_valid = ack_grant | req_grant;

  always_comb begin
    tx_byte = '0;
    if (ack_grant) begin
      tx_byte = TX_RESET_ACK;
    end else if (req_grant) begin
      tx_byte = TX_REQUEST;
    end
  end

  // A new set in the same cycle as a grant keeps the flag raised.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      req_q       <= '0;
      req_pending <= 1'b0;
      ack_pending <= 1'b0;
    end else begin
      req_q       <= request_frame;
      req_pending <= rise | (req_pending & ~req_grant);
      ack_pending <= ack_set | (ack_pending & ~ack_grant);
    end
  end

endmodule

// File: rtl/frame_assembler.sv
// Assembles 4-byte TAS frames from the UART byte stream, broadcasts them as
// queue writes, handles the controller reset command and host requests.
module frame_assembler
  import frame_proto_pkg::*;
#(
  parameter int unsigned NUM_CONSOLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  CMD_FRAME      = CMD_FRAME_DEFAULT,
  parameter logic [7:0]  CMD_RESET      = CMD_RESET_DEFAULT,
  parameter logic [7:0]  TX_REQUEST     = TX_REQUEST_DEFAULT,
  parameter logic [7:0]  TX_RESET_ACK   = TX_RESET_ACK_DEFAULT
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  input  logic [NUM_CONSOLES-1:0] request_frame,
  input  logic                    tx_ready,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  output logic                    queue_WrEn,
  output logic [31:0]             queue_data,
  output logic                    n64_controller_reset,
  output logic                    frame_error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  rx_state_t     state;
  rx_state_t     idle_next;
  logic [1:0]    byte_cnt;
  logic [31:0]   shift_q;
  logic [31:0]   data_q;
  logic [TW-1:0] timeout_q;
  logic [31:0]   shift_next;

  assign shift_next = {shift_q[23:0], rx_byte};

  // WRITE and ACK last one cycle and dispatch a new byte exactly like IDLE.
  always_comb begin
    idle_next = ST_IDLE;
    if (rx_valid) begin
      if (rx_byte == CMD_FRAME) begin
        idle_next = ST_DATA;
      end else if (rx_byte == CMD_RESET) begin
        idle_next = ST_ACK;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      timeout_q   <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        ST_DATA: begin
          if (rx_valid) begin
            shift_q   <= shift_next;
            byte_cnt  <= byte_cnt + 2'd1;
            timeout_q <= '0;
            if (byte_cnt == 2'(FRAME_BYTES - 1)) begin
              data_q <= shift_next;
              state  <= ST_WRITE;
            end
          end else if (timeout_q == TIMEOUT_LAST) begin
            frame_error <= 1'b1;
            shift_q     <= '0;
            byte_cnt    <= '0;
            timeout_q   <= '0;
            state       <= ST_IDLE;
          end else begin
            timeout_q <= timeout_q + 1'b1;
          end
        end
        default: begin
          state <= idle_next;
          if (idle_next == ST_DATA) begin
            byte_cnt  <= '0;
            timeout_q <= '0;
            shift_q   <= '0;
          end
        end
      endcase
    end
  end

  assign queue_WrEn           = (state == ST_WRITE);
  assign queue_data           = data_q;
  assign n64_controller_reset = (state == ST_ACK);

  tx_request_arbiter #(
    .NUM_CONSOLES (NUM_CONSOLES),
    .TX_REQUEST   (TX_REQUEST),
    .TX_RESET_ACK (TX_RESET_ACK)
  ) u_tx_arb (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .request_frame (request_frame),
    .ack_set       (n64_controller_reset),
    .tx_ready      (tx_ready),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid)
  );

endmodule

// File: doc/frame_assembler.md
Name: frame_assembler

Overview:
Upstream stage of the N64 controller queues. Consumes the byte stream from the UART receiver and assembles 4-byte TAS frames. Broadcasts each complete frame as a one-cycle queue write (queue_WrEn/queue_data) to every n64_controller instance, and issues n64_controller_reset on host command. Also converts per-console next-frame requests into request bytes sent back to the host through the UART transmitter.

Parameters:
NUM_CONSOLES, 1, number of console request lines.
TIMEOUT_CYCLES, 5000000, maximum sys_clk gap between bytes inside a frame (100 ms at 50 MHz).
CMD_FRAME, 8'h41, command byte that starts a 4-byte frame.
CMD_RESET, 8'h52, command byte that resets controllers.
TX_REQUEST, 8'h61, byte sent to host to request the next frame.
TX_RESET_ACK, 8'h01, byte sent to host after a reset command.

Ports:
sys_clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
rx_byte  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_byte valid
request_frame  in  NUM_CONSOLES  level; high while a console wants the next frame
tx_ready  in  1  UART transmitter can accept a byte
tx_byte  out  8  byte to transmit
tx_valid  out  1  one-cycle strobe; transmit tx_byte (only when tx_ready)
queue_WrEn  out  1  one-cycle frame write strobe
queue_data  out  32  assembled frame, valid with queue_WrEn
n64_controller_reset  out  1  one-cycle controller reset pulse
frame_error  out  1  one-cycle pulse on an aborted frame

Behaviour:
- Single clock (sys_clk). Reset is asynchronous and active-high and is named reset.
- Reset values: all outputs 0. State IDLE, byte counter 0, shift register 0, timeout counter 0, pending flags 0, request edge register 0.
- Rx states: IDLE, DATA, WRITE, ACK.
- IDLE, rx_valid:
  - byte == CMD_FRAME -> DATA, counter=0, timeout cleared.
  - byte == CMD_RESET -> ACK.
  - any other byte -> ignored, stay IDLE.
- DATA, rx_valid: shift = {shift[23:0], rx_byte}, so the first byte lands in [31:24]. Increment counter and clear timeout. On the 4th byte -> WRITE.
- DATA, no rx_valid: timeout increments. Reaching TIMEOUT_CYCLES-1 -> pulse frame_error, discard partial data, go IDLE.
- DATA: command values are treated as plain data bytes (no escape).
- WRITE: queue_WrEn=1 and queue_data=shift for exactly one cycle, then IDLE.
  - Latency: last rx_valid at cycle N -> queue_WrEn at N+1.
  - queue_data holds its value until the next write.
  - An rx_valid arriving in the WRITE cycle is processed as if in IDLE.
- ACK: n64_controller_reset=1 for one cycle, set ack_pending, then IDLE. Latency is the same as WRITE.
- Request detection: register request_frame each cycle. A rising edge on any bit sets req_pending. Multiple simultaneous or repeated edges coalesce into one pending flag.
- Tx arbiter:
  - When tx_ready and a flag is pending, drive tx_valid for one cycle.
  - ack_pending has priority (tx_byte=TX_RESET_ACK) over req_pending (tx_byte=TX_REQUEST).
  - The serviced flag clears that cycle. If a new edge arrives in the same cycle req_pending is cleared, the new edge wins and the flag stays set.
  - tx_valid is never asserted while tx_ready=0; at most one tx byte per cycle.
- Reset mid-frame: partial frame discarded, no queue_WrEn, pending flags lost.
- Widths: counter 2 bits; timeout counter wide enough for TIMEOUT_CYCLES (clog2), saturating, no wrap-around.

Decomposition:
- Shared package frame_proto_pkg holds the command/response byte constants and the state enum (IDLE, DATA, WRITE, ACK).
- One natural sub-module: tx_request_arbiter. It contains the edge detect, the pending flags, priority selection and the tx handshake. It keeps the rx parser FSM separate and is independently testable.

Test Plan:
1. Send 41 12 34 56 78, one byte every 10 cycles -> one queue_WrEn pulse one cycle after byte 78; queue_data=32'h12345678; no frame_error.
2. Send 52 with tx_ready=1 -> n64_controller_reset pulses one cycle after rx_valid; next cycle tx_valid with tx_byte=01.
3. Send 41 AA BB, then idle for TIMEOUT_CYCLES (set to 100) -> frame_error pulse at the timeout; no queue_WrEn. Next 41 01 02 03 04 -> queue_data=32'h01020304.
4. NUM_CONSOLES=4, raise request_frame bits 0 and 2 in the same cycle while tx_ready=0 for 20 cycles, then tx_ready=1 -> exactly one tx byte 61. A later rising edge on bit 1 -> a second 61.
5. req_pending and ack_pending set together with tx_ready=1 -> first 01, then 61 on the next ready cycle.
6. Assert reset after 41 11 22, release, then send 33 44 -> no queue_WrEn. Outputs are 0 during reset, and 33/44 are ignored in IDLE.
